// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter
// so it can be reused on lines with a different idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with one-cycle valid/frame-error strobes.
// Define UART_RX_PARITY_EN to add a parity bit and the parity_err strobe.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] byte_out,
    output logic       valid_out,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_byte_rx: CLKS_PER_BIT must be >= 4 and PARITY_ODD 0 or 1");
    end

    logic rxs;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rxs)
    );

    rx_state_t     state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          busy_q, busy_d;
    logic          rxs_prev_q, rxs_prev_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bit_q, par_bit_d;
    logic          perr_q, perr_d;
`endif

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        busy_d     = busy_q;
        rxs_prev_d = rxs;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Edge, not level: a line stuck low after a bad frame must go high first.
                if (rxs_prev_q && !rxs) begin
                    state_d    = START;
                    baud_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (baud_cnt_q == HALF_M1) begin
                    if (rxs) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = DATA;
                        baud_cnt_d = '0;
                        bit_idx_d  = '0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_cnt_q == FULL_M1) begin
                    shift_d[bit_idx_q] = rxs;
                    baud_cnt_d         = '0;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt_q == FULL_M1) begin
                    par_bit_d  = rxs;
                    baud_cnt_d = '0;
                    state_d    = STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a following start edge is never missed.
                if (baud_cnt_q == FULL_M1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (par_bit_q != ((^shift_q) ^ PARITY_ODD[0])) begin
                            perr_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            byte_d  = shift_q;
                        end
`else
                        valid_d = 1'b1;
                        byte_d  = shift_q;
`endif
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
            rxs_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
            rxs_prev_q <= rxs_prev_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign byte_out  = byte_q;
    assign valid_out = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at 16 clocks per bit; parity case needs UART_RX_PARITY_EN.
module tb_uart_byte_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] byte_out;
    logic       valid_out, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_byte_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .byte_out  (byte_out),
        .valid_out (valid_out),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, dbl_cnt = 0, excl_cnt = 0;
    int t_fall = 0, t_valid = -1;
    logic prev_v = 1'b0, prev_f = 1'b0, busy_seen = 1'b0;
    logic [7:0] got[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses, records good bytes, flags stretched or overlapping strobes.
    always @(negedge clk) begin
        logic pe;
        pe = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe = parity_err;
`endif
        if (valid_out) begin
            valid_cnt++;
            got.push_back(byte_out);
            if (t_valid < 0) t_valid = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (pe) perr_cnt++;
        if ((valid_out && prev_v) || (frame_err && prev_f)) dbl_cnt++;
        if (int'(valid_out) + int'(frame_err) + int'(pe) > 1) excl_cnt++;
        prev_v = valid_out;
        prev_f = frame_err;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        tick(CPB);
    endtask

    task automatic send_data(input logic [7:0] d);
        t_fall = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_data(d);
        send_bit(stop);
    endtask

    initial begin
        int vb, fb, pb, n, lat;

        rst = 1'b1;
        rx_in = 1'b1;
        tick(4);
        check("rst_byte", 32'(byte_out), 32'h00);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick(4);

        // Single good frame
        vb = valid_cnt; fb = ferr_cnt; n = got.size(); t_valid = -1;
        send_frame(8'hE5, 1'b1);
        tick(CPB);
        check("t1_valid_cnt", 32'(valid_cnt - vb), 32'd1);
        check("t1_byte_q", (got.size() > n) ? 32'(got[n]) : 32'hFFFF, 32'hE5);
        check("t1_byte_out", 32'(byte_out), 32'hE5);
        check("t1_ferr_cnt", 32'(ferr_cnt - fb), 32'd0);
        check("t1_busy", 32'(busy), 32'h0);
        lat = t_valid - t_fall;
        check("t1_latency_ok", 32'(lat >= 154 && lat <= 156), 32'd1);

        // Back-to-back frames
        vb = valid_cnt; n = got.size();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        tick(CPB);
        check("t2_valid_cnt", 32'(valid_cnt - vb), 32'd2);
        check("t2_first", (got.size() > n) ? 32'(got[n]) : 32'hFFFF, 32'h12);
        check("t2_second", (got.size() > n + 1) ? 32'(got[n+1]) : 32'hFFFF, 32'h34);

        // False start
        vb = valid_cnt; fb = ferr_cnt; busy_seen = 1'b0;
        rx_in = 1'b0;
        tick(4);
        rx_in = 1'b1;
        tick(12);
        check("t3_busy_seen", 32'(busy_seen), 32'h1);
        check("t3_busy_low", 32'(busy), 32'h0);
        check("t3_no_valid", 32'(valid_cnt - vb), 32'd0);
        check("t3_no_ferr", 32'(ferr_cnt - fb), 32'd0);
        tick(CPB);

        // Framing error keeps previous byte; line left low must not re-arm
        send_frame(8'h3C, 1'b1);
        tick(CPB);
        vb = valid_cnt; fb = ferr_cnt;
        send_frame(8'hAA, 1'b0);
        tick(CPB * 2);
        check("t4_ferr_cnt", 32'(ferr_cnt - fb), 32'd1);
        check("t4_no_valid", 32'(valid_cnt - vb), 32'd0);
        check("t4_byte_held", 32'(byte_out), 32'h3C);
        check("t4_no_rearm", 32'(busy), 32'h0);
        rx_in = 1'b1;
        tick(CPB * 2);
        check("t4_quiet_after", 32'(valid_cnt - vb + ferr_cnt - fb), 32'd1);

        // Reset during data bit 4 of 0xFF
        vb = valid_cnt; fb = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(8);
        rst = 1'b1;
        tick(2);
        check("t5_byte_zero", 32'(byte_out), 32'h00);
        check("t5_valid_zero", 32'(valid_out), 32'h0);
        check("t5_ferr_zero", 32'(frame_err), 32'h0);
        check("t5_busy_zero", 32'(busy), 32'h0);
        rst = 1'b0;
        tick(CPB * 6);
        check("t5_no_strobe", 32'(valid_cnt - vb + ferr_cnt - fb), 32'd0);
        n = got.size();
        send_frame(8'h5A, 1'b1);
        tick(CPB);
        check("t5_valid_cnt", 32'(valid_cnt - vb), 32'd1);
        check("t5_byte_out", 32'(byte_out), 32'h5A);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        vb = valid_cnt; pb = perr_cnt;
        send_data(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        tick(CPB);
        check("t6_good_valid", 32'(valid_cnt - vb), 32'd1);
        check("t6_good_byte", 32'(byte_out), 32'h07);
        check("t6_good_perr", 32'(perr_cnt - pb), 32'd0);
        vb = valid_cnt; pb = perr_cnt;
        send_data(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(CPB);
        check("t6_bad_perr", 32'(perr_cnt - pb), 32'd1);
        check("t6_bad_no_valid", 32'(valid_cnt - vb), 32'd0);
`else
        pb = perr_cnt;
        check("t6_no_perr", 32'(pb), 32'd0);
`endif

        check("strobe_one_cycle", 32'(dbl_cnt), 32'd0);
        check("strobe_exclusive", 32'(excl_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
